conv_backward_layer: RTL

CONV_BACKWARD_LAYER -- requirements
Module: conv_backward_layer

---
 rtl/conv_backward_layer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/conv_backward_layer.sv
// Backward pass of a 5x7x7 conv layer with sigmoid activation: streams 3920 output positions
// through a 2-stage pipeline, accumulating dw and writing db. Optional saturation: CONV_BWD_SAT_EN.

module conv_bwd_lane #(
  parameter int BUS_WIDTH             = 32,
  parameter int NUM_DECIMAL_IN_BINARY = 6
) (
  input  logic signed [19:0] g,
  input  logic        [14:0] pix,
  output logic signed [25:0] term
);
  logic signed [BUS_WIDTH-1:0] g_w, p_w, prod;

  assign g_w  = BUS_WIDTH'(g);
  assign p_w  = BUS_WIDTH'({1'b0, pix});  // image pixels are non-negative
  assign prod = (g_w * p_w) >>> NUM_DECIMAL_IN_BINARY;
  assign term = 26'(prod);
endmodule

module conv_backward_layer #(
  parameter int BUS_WIDTH             = 32,
  parameter int NUM_DECIMAL_IN_BINARY = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [14:0] img       [0:1119],
  input  logic signed [9:0]  sig_layer [0:4][0:27][0:27],
  input  logic signed [9:0]  delta     [0:4][0:27][0:27],
  output logic signed [25:0] dw        [0:4][0:6][0:6],
  output logic signed [9:0]  db        [0:4][0:27][0:27],
  output logic               done
);
  localparam int F = NUM_DECIMAL_IN_BINARY;
  localparam logic signed [BUS_WIDTH-1:0] ONE = BUS_WIDTH'(1 << F);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COMPUTING, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [2:0] f_cnt;
  logic [4:0] i_cnt, j_cnt;
  logic       drain_cnt, done_nxt, last_pos;

  logic signed [BUS_WIDTH-1:0] sig_w, del_w, s_prime, g_full;
  logic               vld_s1;
  logic signed [19:0] g_s1;
  logic [2:0]         f_s1;
  logic [4:0]         i_s1, j_s1;
  logic [10:0]        pix_base;
  logic signed [25:0] term [0:6][0:6];

  function automatic logic signed [25:0] acc26(input logic signed [25:0] a, input logic signed [25:0] b);
    logic signed [26:0] s;
    s = 27'(a) + 27'(b);
`ifdef CONV_BWD_SAT_EN
    if (s > 27'sd33554431)  return 26'sh1FFFFFF;
    if (s < -27'sd33554432) return 26'sh2000000;
`endif
    return 26'(s);
  endfunction

  function automatic logic signed [9:0] db_of(input logic signed [19:0] g);
`ifdef CONV_BWD_SAT_EN
    if (g > 20'sd511)  return 10'sd511;
    if (g < -20'sd512) return -10'sd512;
`endif
    return 10'(g);
  endfunction

  assign last_pos = (f_cnt == 3'd4) && (i_cnt == 5'd27) && (j_cnt == 5'd27);

  // stage-1 math: sigmoid derivative then chain rule with delta
  always_comb begin
    sig_w   = BUS_WIDTH'(sig_layer[f_cnt][i_cnt][j_cnt]);
    del_w   = BUS_WIDTH'(delta[f_cnt][i_cnt][j_cnt]);
    s_prime = (sig_w * (ONE - sig_w)) >>> F;
    g_full  = (del_w * s_prime) >>> F;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = done;
    case (state)
      S_IDLE:      begin done_nxt = 1'b0; if (start) state_nxt = S_CLEAR; end
      S_CLEAR:     state_nxt = S_COMPUTING;
      S_COMPUTING: if (last_pos) state_nxt = S_DRAIN;
      S_DRAIN:     if (drain_cnt) state_nxt = S_DONE;
      S_DONE: begin
        done_nxt = 1'b1;
        // done is guaranteed visible for at least one cycle even if start already fell
        if (!start && done) begin state_nxt = S_IDLE; done_nxt = 1'b0; end
      end
      default:     begin state_nxt = S_IDLE; done_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; done <= 1'b0; drain_cnt <= 1'b0;
      f_cnt <= '0; i_cnt <= '0; j_cnt <= '0;
      vld_s1 <= 1'b0; g_s1 <= '0; f_s1 <= '0; i_s1 <= '0; j_s1 <= '0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      vld_s1 <= (state == S_COMPUTING);
      if (state == S_COMPUTING) begin
        g_s1 <= 20'(g_full); f_s1 <= f_cnt; i_s1 <= i_cnt; j_s1 <= j_cnt;
      end
      case (state)
        S_CLEAR: begin f_cnt <= '0; i_cnt <= '0; j_cnt <= '0; drain_cnt <= 1'b0; end
        S_COMPUTING: begin
          if (j_cnt == 5'd27) begin
            j_cnt <= '0;
            if (i_cnt == 5'd27) begin
              i_cnt <= '0;
              f_cnt <= (f_cnt == 3'd4) ? 3'd0 : f_cnt + 3'd1;
            end else i_cnt <= i_cnt + 5'd1;
          end else j_cnt <= j_cnt + 5'd1;
        end
        S_DRAIN: drain_cnt <= ~drain_cnt;
        default: ;
      endcase
    end
  end

  // top-left of the 7x7 window: row i+1, column j-2 of the padded image
  assign pix_base = {1'b0, i_s1, 5'b0} + 11'd32 + 11'(j_s1) - 11'd2;

  for (genvar k = 0; k < 7; k++) begin : g_row
    for (genvar l = 0; l < 7; l++) begin : g_col
      logic [10:0] idx;
      assign idx = pix_base + 11'(k * 32 + l);
      conv_bwd_lane #(.BUS_WIDTH(BUS_WIDTH), .NUM_DECIMAL_IN_BINARY(F)) u_lane (
        .g(g_s1), .pix(img[idx]), .term(term[k][l])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 5; a++) begin
        for (int b = 0; b < 7; b++) for (int c = 0; c < 7; c++) dw[a][b][c] <= '0;
        for (int b = 0; b < 28; b++) for (int c = 0; c < 28; c++) db[a][b][c] <= '0;
      end
    end else if (state == S_CLEAR) begin
      for (int a = 0; a < 5; a++)
        for (int b = 0; b < 7; b++) for (int c = 0; c < 7; c++) dw[a][b][c] <= '0;
    end else if (vld_s1) begin
      for (int b = 0; b < 7; b++)
        for (int c = 0; c < 7; c++) dw[f_s1][b][c] <= acc26(dw[f_s1][b][c], term[b][c]);
      db[f_s1][i_s1][j_s1] <= db_of(g_s1);
    end
  end
endmodule
